// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch realignment buffer.
package fetch_pkg;
    localparam int          FETCH_LINE_W = 64;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [1:0]  RVC_MASK     = 2'b11;

    typedef logic [31:3] line_tag_t;

    typedef struct packed {
        logic                    v;
        line_tag_t               tag;
        logic [FETCH_LINE_W-1:0] data;
    } slot_t;

    typedef struct packed {
        logic                    hit;
        logic [FETCH_LINE_W-1:0] data;
    } lookup_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} slot_state_e;

    // Incoming SRAM data wins over slot contents so a same-cycle capture is seen.
    function automatic lookup_t line_lookup(input line_tag_t t, input logic cs,
                                            input line_tag_t adr,
                                            input logic [FETCH_LINE_W-1:0] rdata,
                                            input slot_t s0, input slot_t s1);
        lookup_t r;
        r.hit  = 1'b0;
        r.data = '0;
        if (cs && adr == t) begin
            r.hit  = 1'b1;
            r.data = rdata;
        end else if (s0.v && s0.tag == t) begin
            r.hit  = 1'b1;
            r.data = s0.data;
        end else if (s1.v && s1.tag == t) begin
            r.hit  = 1'b1;
            r.data = s1.data;
        end
        return r;
    endfunction
endpackage

// File: rtl/fetch_hw_sel.sv
// Picks one 16-bit halfword out of an 8-byte fetch line.
module fetch_hw_sel
    import fetch_pkg::*;
(
    input  logic [FETCH_LINE_W-1:0] line,
    input  logic [1:0]              idx,
    output logic [15:0]             hw
);
    always_comb begin
        case (idx)
            2'd0:    hw = line[15:0];
            2'd1:    hw = line[31:16];
            2'd2:    hw = line[47:32];
            default: hw = line[63:48];
        endcase
    end
endmodule

// File: rtl/fetch_align.sv
// Two-line realignment buffer: extracts the 16/32-bit instruction at pc and
// stitches 32-bit instructions that straddle an 8-byte line boundary.
module fetch_align #(
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic [31:0] pc,
    input  logic [63:0] isram_rdata,
    input  logic        isram_cs_ff,
    input  logic [28:0] isram_adr_ff,
    input  logic        flush,
    output logic [31:0] rv32_instr,
    output logic        isrv16,
    output logic        instr_valid,
    output logic        fetch_misalign,
    output logic [31:0] instr_pc
);
    import fetch_pkg::*;

    slot_t       slot_q [2];
    slot_state_e state_q, state_d;
    line_tag_t   tag_l0, tag_l1, adr;
    logic [1:0]  h, hi_idx;
    lookup_t     lk0, lk1;
    logic [15:0] lo_hw, hi_hw;
    logic        hi_hit, rvc, valid;

    assign adr      = isram_adr_ff;
    assign tag_l0   = pc[31:3];
    assign tag_l1   = tag_l0 + 29'd1;
    assign h        = pc[2:1];
    assign hi_idx   = h + 2'd1;
    assign instr_pc = pc & ~32'h1;

    assign lk0 = line_lookup(tag_l0, isram_cs_ff, adr, isram_rdata, slot_q[0], slot_q[1]);
    assign lk1 = line_lookup(tag_l1, isram_cs_ff, adr, isram_rdata, slot_q[0], slot_q[1]);

    fetch_hw_sel u_lo_sel (.line(lk0.data), .idx(h), .hw(lo_hw));
    fetch_hw_sel u_hi_sel (.line((h == 2'd3) ? lk1.data : lk0.data), .idx(hi_idx), .hw(hi_hw));

    assign hi_hit = (h == 2'd3) ? lk1.hit : lk0.hit;
    assign rvc    = lo_hw[1:0] != RVC_MASK;
    assign valid  = lk0.hit && (rvc || hi_hit);

    // Outputs held at their idle values while reset is asserted.
    always_comb begin
        instr_valid    = 1'b0;
        fetch_misalign = 1'b0;
        isrv16         = 1'b0;
        rv32_instr     = NOP_INSTR;
        if (cpurst_n) begin
            if (valid) begin
                instr_valid = 1'b1;
                isrv16      = rvc;
                rv32_instr  = rvc ? {16'h0, lo_hw} : {hi_hw, lo_hw};
            end else begin
                fetch_misalign = 1'b1;
            end
        end
    end

    // Capture target; a flush makes both slots look free so the redirect line lands in slot0.
    logic [1:0] v_eff, match, stale, cap_we;
    always_comb begin
        cap_we = 2'b00;
        for (int i = 0; i < 2; i++) begin
            v_eff[i] = slot_q[i].v && !flush;
            match[i] = v_eff[i] && slot_q[i].tag == adr;
            stale[i] = slot_q[i].tag != tag_l0 && slot_q[i].tag != tag_l1;
        end
        if (isram_cs_ff) begin
            if      (match[0])  cap_we = 2'b01;
            else if (match[1])  cap_we = 2'b10;
            else if (!v_eff[0]) cap_we = 2'b01;
            else if (!v_eff[1]) cap_we = 2'b10;
            else if (stale[0])  cap_we = 2'b01;
            else if (stale[1])  cap_we = 2'b10;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = isram_cs_ff ? ST_ONE : ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (isram_cs_ff) state_d = ST_ONE;
                ST_ONE:   if (isram_cs_ff && match == 2'b00) state_d = ST_TWO;
                default:  state_d = ST_TWO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q <= ST_EMPTY;
            for (int i = 0; i < 2; i++) slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 2; i++) begin
                if (cap_we[i]) begin
                    slot_q[i].v    <= 1'b1;
                    slot_q[i].tag  <= adr;
                    slot_q[i].data <= isram_rdata;
                end else if (flush) begin
                    slot_q[i].v <= 1'b0;
                end
            end
        end
    end
endmodule
